hdlc_tx_framer: RTL

- HDLC transmit framer. Takes frame bytes from the TX buffer and serialises them onto Tx at one bit per Clk.
- Generates the start/end flag (01111110), performs zero insertion on frame content, generates the abort flag (11111110), and drives the idle pattern (all ones).
- Sits between the TX buffer and the serial line. It is the transmit-side counterpart of the Rx flag/abort/EoF detection path.

---
 rtl/hdlc_tx_framer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: serialises buffered frame bytes LSB first with start/end
// flags, zero insertion, abort flags and an all-ones idle line.
module hdlc_tx_framer #(
    parameter int IDLE_FLAGS = 0
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tx_Enable,
    input  logic       Tx_AbortFrame,
    input  logic [7:0] Tx_Data,
    input  logic       Tx_DataValid,
    input  logic       Tx_DataLast,
    output logic       Tx_RdBuff,
    output logic       Tx,
    output logic       Tx_ValidFrame,
    output logic       Tx_AbortedTrans,
    output logic       Tx_Done
);

    localparam int PRE_W = (IDLE_FLAGS > 0) ? $clog2(IDLE_FLAGS + 1) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'((IDLE_FLAGS > 0) ? IDLE_FLAGS - 1 : 0);

    typedef enum logic [2:0] {
        IDLE, PRE_FLAG, START_FLAG, DATA, END_FLAG, ABORT_FLAG
    } FramerState;

    FramerState       state, stateNext;
    logic [2:0]       bitCnt, bitCntNext;
    logic [2:0]       onesCnt, onesNext;
    logic [7:0]       shiftReg, shiftNext;
    logic             lastByte, lastNext;
    logic [PRE_W-1:0] preCnt, preNext;
    logic             txReg, txNext;
    logic             loadCycle, stuffing, dataBit;
    logic [2:0]       onesAfter;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= IDLE;
            bitCnt   <= '0;
            onesCnt  <= '0;
            shiftReg <= '0;
            lastByte <= 1'b0;
            preCnt   <= '0;
            txReg    <= 1'b1;
        end else begin
            state    <= stateNext;
            bitCnt   <= bitCntNext;
            onesCnt  <= onesNext;
            shiftReg <= shiftNext;
            lastByte <= lastNext;
            preCnt   <= preNext;
            txReg    <= txNext;
        end
    end

    // A stuffed zero holds the bit counter; the byte ends after any trailing stuff bit.
    always_comb begin
        stateNext  = state;
        bitCntNext = bitCnt;
        onesNext   = onesCnt;
        shiftNext  = shiftReg;
        lastNext   = lastByte;
        preNext    = preCnt;
        Tx_RdBuff  = 1'b0;
        loadCycle  = 1'b0;
        dataBit    = shiftReg[bitCnt];
        stuffing   = (onesCnt == 3'd5);
        onesAfter  = dataBit ? onesCnt + 3'd1 : 3'd0;

        case (state)
            IDLE: begin
                if (Tx_Enable) begin
                    stateNext  = (IDLE_FLAGS > 0) ? PRE_FLAG : START_FLAG;
                    bitCntNext = '0;
                    onesNext   = '0;
                    preNext    = '0;
                    lastNext   = 1'b0;
                end
            end
            PRE_FLAG: begin
                bitCntNext = bitCnt + 3'd1;
                if (bitCnt == 3'd7) begin
                    if (preCnt == PRE_LAST) stateNext = START_FLAG;
                    else preNext = preCnt + PRE_W'(1);
                end
            end
            START_FLAG: begin
                bitCntNext = bitCnt + 3'd1;
                onesNext   = '0;
                loadCycle  = (bitCnt == 3'd7);
            end
            DATA: begin
                if (stuffing) begin
                    onesNext   = '0;
                    bitCntNext = bitCnt + 3'd1;
                    loadCycle  = (bitCnt == 3'd7);
                end else begin
                    onesNext = onesAfter;
                    if (onesAfter != 3'd5) begin
                        bitCntNext = bitCnt + 3'd1;
                        loadCycle  = (bitCnt == 3'd7);
                    end
                end
            end
            END_FLAG, ABORT_FLAG: begin
                bitCntNext = bitCnt + 3'd1;
                if (bitCnt == 3'd7) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase

        if (loadCycle) begin
            if (lastByte) begin
                stateNext = END_FLAG;
            end else if (Tx_DataValid) begin
                Tx_RdBuff = 1'b1;
                shiftNext = Tx_Data;
                lastNext  = Tx_DataLast;
                stateNext = DATA;
            end else begin
                stateNext = ABORT_FLAG;
            end
        end

        if ((state == PRE_FLAG || state == START_FLAG || state == DATA) && Tx_AbortFrame) begin
            stateNext  = ABORT_FLAG;
            bitCntNext = '0;
            onesNext   = '0;
        end

        case (stateNext)
            PRE_FLAG, START_FLAG, END_FLAG: txNext = (bitCntNext != 3'd0) && (bitCntNext != 3'd7);
            ABORT_FLAG:                     txNext = (bitCntNext != 3'd0);
            DATA:                           txNext = (onesNext == 3'd5) ? 1'b0 : shiftNext[bitCntNext];
            default:                        txNext = 1'b1;
        endcase
    end

    assign Tx              = txReg;
    assign Tx_ValidFrame   = (state == PRE_FLAG) || (state == START_FLAG) || (state == DATA);
    assign Tx_AbortedTrans = (state == ABORT_FLAG) && (bitCnt == 3'd0);
    assign Tx_Done         = (state == END_FLAG) && (bitCnt == 3'd7);

endmodule
